// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write-path packer.
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  localparam int unsigned WORDS_PER_BEAT = 8;
  localparam int unsigned BEAT_BYTES     = 32;

endpackage

// File: rtl/ddr_wr_packer_if.sv
// Input word stream plus DDR user write port (command and data channels).
interface ddr_wr_packer_if #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = 256,
  parameter int unsigned ADDR_WIDTH = 28
);

  logic                  s_valid;
  logic                  s_ready;
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_last;
  logic                  wr_cmd_valid;
  logic                  wr_cmd_ready;
  logic [ADDR_WIDTH-1:0] wr_cmd_addr;
  logic [7:0]            wr_cmd_len;
  logic                  wr_data_valid;
  logic                  wr_data_ready;
  logic [OUT_WIDTH-1:0]  wr_data;
  logic                  wr_data_last;

  // master: the packer itself; slave: word source and DDR controller side
  modport master (
    input  s_valid, s_data, s_last, wr_cmd_ready, wr_data_ready,
    output s_ready, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
           wr_data_valid, wr_data, wr_data_last
  );

  modport slave (
    output s_valid, s_data, s_last, wr_cmd_ready, wr_data_ready,
    input  s_ready, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
           wr_data_valid, wr_data, wr_data_last
  );

endinterface

// File: rtl/ddr_wr_sync_fifo.sv
// Single-clock first-word-fall-through beat FIFO with occupancy output.
module ddr_wr_sync_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ddr_wr_packer.sv
// Packs a 32-bit word stream into 256-bit beats and issues fixed-length
// DDR write bursts (command, then data beats) from a local beat FIFO.
module ddr_wr_packer
  import ddr_wr_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = 256,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned BUF_AW     = 5,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(32'h0010_0000)
) (
  input  logic            clk,
  input  logic            rst_n,
  ddr_wr_packer_if.master bus,
  output logic [BUF_AW:0] buf_level,
  output logic            frame_done
);

  localparam int unsigned LVL_W = BUF_AW + 1;
  localparam int unsigned SUM_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(1 << BUF_AW);
  localparam logic [2:0]       LAST_WORD = 3'(WORDS_PER_BEAT - 1);

  state_t                state, state_nxt;
  logic [2:0]            word_cnt;
  logic [OUT_WIDTH-1:0]  beat_q, beat_c, head;
  logic [LVL_W-1:0]      level, lvl_len;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [SUM_W-1:0]      addr_sum;
  logic [7:0]            cmd_len, beat_cnt;
  logic                  accept, push, pop, flush_pending;
  logic                  cmd_valid, data_valid, data_last, latch_cmd, frame_evt;

  assign bus.s_ready = rst_n & ~flush_pending & ((level < DEPTH_LVL) | pop);
  assign accept      = bus.s_valid & bus.s_ready;
  assign push        = accept & (bus.s_last | (word_cnt == LAST_WORD));
  assign lvl_len     = (level >= BURST_LVL) ? BURST_LVL : level;
  assign addr_sum    = {1'b0, addr} + SUM_W'((32'(cmd_len) + 32'd1) * BEAT_BYTES);
  assign addr_nxt    = (addr_sum >= {1'b0, ADDR_LIMIT}) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];

  // Insert the incoming word into its lane; unused upper lanes stay zero
  always_comb begin
    beat_c = beat_q;
    beat_c[32'(word_cnt) * IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  // Word packer: accumulate lanes until a full beat or end of frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
      beat_q   <= '0;
    end else if (accept) begin
      if (push) begin
        word_cnt <= '0;
        beat_q   <= '0;
      end else begin
        word_cnt <= word_cnt + 3'd1;
        beat_q   <= beat_c;
      end
    end
  end

  ddr_wr_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .AW    (BUF_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (beat_c),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and channel strobes
  always_comb begin
    state_nxt  = state;
    cmd_valid  = 1'b0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    pop        = 1'b0;
    latch_cmd  = 1'b0;
    frame_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        if ((level >= BURST_LVL) || (flush_pending && (level != '0))) begin
          state_nxt = CMD;
          latch_cmd = 1'b1;
        end else if (flush_pending && !frame_done) begin
          frame_evt = 1'b1;
        end
      end
      CMD: begin
        cmd_valid = 1'b1;
        if (bus.wr_cmd_ready) state_nxt = DATA;
      end
      DATA: begin
        data_valid = (level != '0);
        data_last  = data_valid && (beat_cnt == cmd_len);
        pop        = data_valid && bus.wr_data_ready;
        if (pop && (beat_cnt == cmd_len)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length, beat count, address, and end-of-frame bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr          <= BASE_ADDR;
      cmd_len       <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= frame_evt;
      if (accept && bus.s_last) flush_pending <= 1'b1;
      else if (frame_done)      flush_pending <= 1'b0;
      if (latch_cmd) begin
        cmd_len  <= 8'(lvl_len) - 8'd1;
        beat_cnt <= '0;
      end
      if (pop) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (beat_cnt == cmd_len) addr <= addr_nxt;
      end
      if (frame_done) addr <= BASE_ADDR;
    end
  end

  assign bus.wr_cmd_valid  = cmd_valid;
  assign bus.wr_cmd_addr   = addr;
  assign bus.wr_cmd_len    = cmd_len;
  assign bus.wr_data_valid = data_valid;
  assign bus.wr_data_last  = data_last;
  assign bus.wr_data       = data_valid ? head : '0;
  assign buf_level         = level;

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Directed/randomized bench for ddr_wr_packer with a frame-level reference model.
module tb_ddr_wr_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] lvl_a, lvl_b;
  logic       fd_a, fd_b;

  always #5 clk = ~clk;

  ddr_wr_packer_if ifa ();
  ddr_wr_packer_if ifb ();

  ddr_wr_packer dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .buf_level(lvl_a), .frame_done(fd_a)
  );

  ddr_wr_packer #(.ADDR_LIMIT(28'd1024)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .buf_level(lvl_b), .frame_done(fd_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc = 0, fd_cnt_a = 0, fd_cnt_b = 0, fd_cyc = 0, last_beat_cyc = 0;
  bit fd_sready;
  bit rnd_mode = 1'b0;

  logic [31:0]  words_a[$], words_b[$];
  logic [255:0] beats_a[$], beats_b[$];
  bit           lasts_a[$], lasts_b[$];
  logic [35:0]  cmds_a[$],  cmds_b[$];

  // Record handshakes mid-cycle; they complete on the following rising edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (ifa.wr_cmd_valid && ifa.wr_cmd_ready) cmds_a.push_back({ifa.wr_cmd_addr, ifa.wr_cmd_len});
      if (ifa.wr_data_valid && ifa.wr_data_ready) begin
        beats_a.push_back(ifa.wr_data);
        lasts_a.push_back(ifa.wr_data_last);
        last_beat_cyc <= cyc;
      end
      if (fd_a) begin
        fd_cnt_a  <= fd_cnt_a + 1;
        fd_cyc    <= cyc;
        fd_sready <= ifa.s_ready;
      end
      if (ifb.wr_cmd_valid && ifb.wr_cmd_ready) cmds_b.push_back({ifb.wr_cmd_addr, ifb.wr_cmd_len});
      if (ifb.wr_data_valid && ifb.wr_data_ready) begin
        beats_b.push_back(ifb.wr_data);
        lasts_b.push_back(ifb.wr_data_last);
      end
      if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; optionally jitter the ready inputs
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      ifa.wr_data_ready = ($urandom_range(0, 3) != 0);
      ifa.wr_cmd_ready  = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic send_word(input bit sel, input logic [31:0] d, input bit last);
    bit acc = 1'b0;
    int n = 0;
    if (rnd_mode && ($urandom_range(0, 3) == 0)) tick();
    if (sel) begin ifb.s_valid = 1'b1; ifb.s_data = d; ifb.s_last = last; end
    else     begin ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_last = last; end
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = sel ? (ifb.s_ready === 1'b1) : (ifa.s_ready === 1'b1);
      tick();
      n++;
    end
    if (sel) begin ifb.s_valid = 1'b0; ifb.s_last = 1'b0; end
    else     begin ifa.s_valid = 1'b0; ifa.s_last = 1'b0; end
    if (acc) begin
      if (sel) words_b.push_back(d);
      else     words_a.push_back(d);
    end else begin
      chk("s_ready_timeout", 256'(acc), 256'(1));
    end
  endtask

  task automatic send_frame(input bit sel, input int n, input bit last);
    for (int i = 0; i < n; i++) send_word(sel, $urandom, last && (i == n - 1));
  endtask

  task automatic wait_done(input bit sel);
    int start = sel ? fd_cnt_b : fd_cnt_a;
    int n = 0;
    while ((sel ? fd_cnt_b : fd_cnt_a) == start && n < 3000) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 256'((sel ? fd_cnt_b : fd_cnt_a) - start), 256'(1));
  endtask

  task automatic clear_all();
    words_a.delete(); beats_a.delete(); lasts_a.delete(); cmds_a.delete();
    words_b.delete(); beats_b.delete(); lasts_b.delete(); cmds_b.delete();
  endtask

  // Reference: beats are 8-word groups (zero padded); bursts are 16-beat chunks
  // with a short tail, addresses advance by 32 B/beat and wrap at the limit
  task automatic check_frame(input bit sel, input int unsigned limit, input string nm);
    logic [31:0]  w[$];
    logic [255:0] gb[$], eb[$];
    bit           gl[$], el[$];
    logic [35:0]  gc[$], ec[$];
    logic [255:0] b;
    int unsigned  addr = 0;
    int           rem, len;
    if (sel) begin w = words_b; gb = beats_b; gl = lasts_b; gc = cmds_b; end
    else     begin w = words_a; gb = beats_a; gl = lasts_a; gc = cmds_a; end
    for (int i = 0; i < w.size(); i += 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) if (i + k < w.size()) b[k*32 +: 32] = w[i+k];
      eb.push_back(b);
    end
    rem = eb.size();
    while (rem > 0) begin
      len = (rem > 16) ? 16 : rem;
      ec.push_back({28'(addr), 8'(len - 1)});
      for (int j = 0; j < len; j++) el.push_back(j == len - 1);
      addr = addr + 32'(len * 32);
      if (addr >= limit) addr = 0;
      rem -= len;
    end
    chk({nm, "_ncmd"}, 256'(gc.size()), 256'(ec.size()));
    for (int i = 0; i < ec.size() && i < gc.size(); i++)
      chk($sformatf("%s_cmd%0d", nm, i), 256'(gc[i]), 256'(ec[i]));
    chk({nm, "_nbeat"}, 256'(gb.size()), 256'(eb.size()));
    for (int i = 0; i < eb.size() && i < gb.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i), gb[i], eb[i]);
      chk($sformatf("%s_last%0d", nm, i), 256'(gl[i]), 256'(el[i]));
    end
    clear_all();
  endtask

  initial begin
    int cur;
    bit seen_low;
    rst_n = 1'b0;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0;
    ifa.wr_cmd_ready = 1'b1; ifa.wr_data_ready = 1'b1;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0;
    ifb.wr_cmd_ready = 1'b1; ifb.wr_data_ready = 1'b1;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_s_ready",    256'(ifa.s_ready), 256'(0));
    chk("rst_cmd_valid",  256'(ifa.wr_cmd_valid), 256'(0));
    chk("rst_data_valid", 256'(ifa.wr_data_valid), 256'(0));
    chk("rst_data_last",  256'(ifa.wr_data_last), 256'(0));
    chk("rst_frame_done", 256'(fd_a), 256'(0));
    chk("rst_buf_level",  256'(lvl_a), 256'(0));
    chk("rst_cmd_addr",   256'(ifa.wr_cmd_addr), 256'(0));
    chk("rst_cmd_len",    256'(ifa.wr_cmd_len), 256'(0));
    chk("rst_wr_data",    ifa.wr_data, 256'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", 256'(ifa.s_ready), 256'(1));
    tick();
    clear_all();

    // 128 words: one 16-beat burst, word0 in the low lane
    send_frame(0, 128, 1);
    wait_done(0);
    if (beats_a.size() > 0) chk("A_word0_lsb", 256'(beats_a[0][31:0]), 256'(words_a[0]));
    chk("A_addr_rewound", 256'(ifa.wr_cmd_addr), 256'(0));
    check_frame(0, 32'h0010_0000, "A");

    // 8 words: single-beat burst, frame_done latency and s_ready release
    send_frame(0, 8, 1);
    wait_done(0);
    chk("B_done_latency", 256'(fd_cyc - last_beat_cyc), 256'(2));
    chk("B_s_ready_in_done", 256'(fd_sready), 256'(0));
    @(negedge clk);
    chk("B_s_ready_after_done", 256'(ifa.s_ready), 256'(1));
    chk("B_addr_base", 256'(ifa.wr_cmd_addr), 256'(0));
    tick();
    check_frame(0, 32'h0010_0000, "B");

    // 11 words: zero-padded partial second beat
    send_frame(0, 11, 1);
    wait_done(0);
    if (beats_a.size() > 1) chk("C_pad_zero", 256'(beats_a[1][255:96]), 256'(0));
    check_frame(0, 32'h0010_0000, "C");

    // Randomized frame length, valid gaps and controller readiness
    rnd_mode = 1'b1;
    send_frame(0, $urandom_range(90, 200), 1);
    wait_done(0);
    rnd_mode = 1'b0;
    ifa.wr_cmd_ready = 1'b1; ifa.wr_data_ready = 1'b1;
    check_frame(0, 32'h0010_0000, "E");

    // Data-channel stall: buffer saturates, then drains without loss
    ifa.wr_data_ready = 1'b0;
    seen_low = 1'b0;
    cur = $urandom;
    ifa.s_valid = 1'b1; ifa.s_data = 32'(cur); ifa.s_last = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ifa.s_ready) begin
        words_a.push_back(32'(cur));
        cur = $urandom;
      end else begin
        seen_low = 1'b1;
      end
      tick();
      ifa.s_data = 32'(cur);
    end
    ifa.s_valid = 1'b0;
    @(negedge clk);
    chk("D_level_full", 256'(lvl_a), 256'(32));
    chk("D_s_ready_low", 256'(ifa.s_ready), 256'(0));
    chk("D_seen_low", 256'(seen_low), 256'(1));
    chk("D_words_taken", 256'(words_a.size()), 256'(256));
    tick();
    ifa.wr_data_ready = 1'b1;
    send_frame(0, 20, 1);
    wait_done(0);
    check_frame(0, 32'h0010_0000, "D");

    // Reset while a burst is stalled in its data phase
    ifa.wr_data_ready = 1'b0;
    send_frame(0, 130, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("R_in_data", 256'(ifa.wr_data_valid), 256'(1));
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("R_s_ready",    256'(ifa.s_ready), 256'(0));
    chk("R_cmd_valid",  256'(ifa.wr_cmd_valid), 256'(0));
    chk("R_data_valid", 256'(ifa.wr_data_valid), 256'(0));
    chk("R_data_last",  256'(ifa.wr_data_last), 256'(0));
    chk("R_buf_level",  256'(lvl_a), 256'(0));
    chk("R_cmd_addr",   256'(ifa.wr_cmd_addr), 256'(0));
    chk("R_cmd_len",    256'(ifa.wr_cmd_len), 256'(0));
    tick();
    rst_n = 1'b1;
    clear_all();
    ifa.wr_data_ready = 1'b1;
    send_frame(0, 8, 1);
    wait_done(0);
    check_frame(0, 32'h0010_0000, "R");

    // Address wrap with a 1 KiB window: 0, 512, 0, 512
    send_frame(1, 512, 1);
    wait_done(1);
    chk("W_level_empty", 256'(lvl_b), 256'(0));
    check_frame(1, 1024, "W");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_wr_packer.md
# ddr_wr_packer

Single-clock write-path packer for the DDR frame buffer. It collects a 32-bit pixel/sample stream into 256-bit DDR beats and buffers them in a local FIFO. It then issues fixed-length write bursts, each as a command plus its data beats, to the DDR controller's user write port. It mirrors the read-side 256→32 FIFO: every frame written here is later read back through that path.

## Interface
- IN_WIDTH, 32, input word width
- OUT_WIDTH, 256, DDR beat width; must equal IN_WIDTH × WORDS_PER_BEAT (8)
- BURST_LEN, 16, nominal beats per burst (1..2^BUF_AW)
- BUF_AW, 5, beat buffer address width (32 entries)
- ADDR_WIDTH, 28, DDR byte address width
- BASE_ADDR, 0, frame start byte address (32-byte aligned)
- ADDR_LIMIT, 28'h0100000, exclusive wrap address; (ADDR_LIMIT−BASE_ADDR) is a multiple of 32

Ports:
- clk  in  1  DDR user clock
- rst_n  in  1  synchronous reset, active low; one clock, reset synchronous active-low
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  IN_WIDTH  input word
- s_last  in  1  last word of frame, qualified by s_valid
- wr_cmd_valid  out  1  burst command valid
- wr_cmd_ready  in  1  controller accepts command
- wr_cmd_addr  out  ADDR_WIDTH  burst start byte address
- wr_cmd_len  out  8  beats in burst minus 1
- wr_data_valid  out  1  beat valid
- wr_data_ready  in  1  controller accepts beat
- wr_data  out  OUT_WIDTH  beat data
- wr_data_last  out  1  final beat of burst
- buf_level  out  BUF_AW+1  beats held in buffer
- frame_done  out  1  one-cycle pulse after a frame is fully written

## Operation
- Packing: word k (0..7) of a beat goes to bits [32k+31:32k], so the first word is in the LSBs. A 3-bit word counter counts accepted words. On the 8th word, or on s_last, the assembled beat is pushed and the counter clears. A partial beat on s_last is zero-padded.
- s_ready is 1 only when the buffer can take a push in the same cycle (level < 2^BUF_AW, or a pop is occurring) and no flush is pending.
- flush_pending is set when s_last is accepted. While it is set, s_ready = 0.
- FSM states:
  - IDLE: go to CMD when level ≥ BURST_LEN, or when flush_pending and level > 0. Latch len = min(level, BURST_LEN). If flush_pending and level == 0, pulse frame_done, clear flush_pending, reset addr to BASE_ADDR, and stay in IDLE.
  - CMD: hold wr_cmd_valid with stable addr and len−1 until wr_cmd_ready, then go to DATA.
  - DATA: present the buffer head. Pop on wr_data_valid & wr_data_ready. wr_data_last is asserted on the len-th beat. After that beat: addr += len×32; if the result ≥ ADDR_LIMIT, addr = BASE_ADDR. Return to IDLE.
- Commands never overlap: a command is issued only in IDLE.
- Buffer underflow in DATA is impossible, because len ≤ level was latched at command time and only packing adds entries.

## Timing
- Reset values: s_ready 0 during reset, 1 on the first cycle after reset. wr_cmd_valid, wr_data_valid, wr_data_last, frame_done and buf_level are 0. wr_cmd_addr = BASE_ADDR. wr_cmd_len, wr_data = 0. State is IDLE and the word counter is 0.
- Push latency: a beat completed on cycle N is counted in buf_level at N+1. Simultaneous push and pop leave the level unchanged.
- Command latency: level reaching BURST_LEN at cycle N gives wr_cmd_valid at N+1 (IDLE evaluates on registered level).
- Data: wr_data_valid rises the cycle after the command handshake. The buffer is first-word-fall-through, so back-to-back beats run at 1 beat/clk under continuous wr_data_ready.
- frame_done fires one cycle after IDLE observes flush_pending with level 0. s_ready returns high the cycle after frame_done.
- Reset mid-burst: all state is dropped and no wr_data_last is issued. The controller must also be reset.

## Structure
- Package ddr_wr_pkg holds:
  - the state enum {IDLE, CMD, DATA}
  - WORDS_PER_BEAT = 8
  - BEAT_BYTES = 32
- Sub-module ddr_wr_sync_fifo: a single-clock, FWFT, OUT_WIDTH×2^BUF_AW FIFO with a level output and synchronous active-low reset.
- Top level holds the packer, FSM, address counter and flush logic.

## Test plan
- 128 consecutive words, no backpressure, BURST_LEN 16 → one command (addr 0, len 15) and 16 beats; beat0 = words 7..0 with word0 in [31:0]; wr_data_last on beat 16.
- 8 words, s_last on word 8 → one command with len 0, one beat with wr_data_last; frame_done 1 cycle after that beat; next addr = BASE_ADDR.
- 11 words, s_last on word 11 → 2 beats; beat1 holds words 8..10 in [95:0] and zeros in [255:96]; command len 1.
- wr_data_ready low for 300 cycles while input runs → buf_level saturates at 32 and s_ready drops; no word is lost or duplicated in the scoreboard once ready is restored.
- ADDR_LIMIT = BASE_ADDR + 1024 and 64 beats written → command addresses 0, 512, 0, 512.
- rst_n asserted mid-DATA → all outputs take reset values on the next clock; a new frame starts at BASE_ADDR with the word counter at 0.
